// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding scoreboard.
package pipe_pkg;

  localparam int LAT_ALU     = 1;
  localparam int LAT_LOAD    = 2;
  localparam int FWD_REGFILE = 0;

  // Entry fields are sized for the widest supported build (32+ regs, DEPTH <= 16).
  localparam int ENT_RD_W  = 8;
  localparam int ENT_LAT_W = 4;

  typedef struct packed {
    logic                 v;
    logic [ENT_RD_W-1:0]  rd;
    logic [ENT_LAT_W-1:0] lat;
  } entry_t;

  // Latency 0 behaves as 1; anything beyond WB is forwardable at WB.
  function automatic logic [ENT_LAT_W-1:0] eff_lat(input int lat, input int depth);
    int l;
    l = lat;
    if (l < 1) l = 1;
    if (l > depth - 1) l = depth - 1;
    return ENT_LAT_W'(l);
  endfunction

endpackage

// File: rtl/pipe_scoreboard_if.sv
// ID-stage request and scoreboard response bundle for pipe_scoreboard.
interface pipe_scoreboard_if #(
  parameter int REG_AW = 5,
  parameter int LAT_W  = 2,
  parameter int CNT_W  = 32,
  parameter int FW_W   = 2
);
  // No valid/ready pair here: advance is the single qualifier. Every ID field
  // is sampled on a clock edge only when advance=1; stall/id_bypass are
  // combinational answers to the current ID fields and never wait on advance.
  logic              advance;
  logic              flush;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic [LAT_W-1:0]  id_lat;
  logic              stall;
  logic              id_bypass1;
  logic              id_bypass2;
  logic [FW_W-1:0]   ex_fwd1;
  logic [FW_W-1:0]   ex_fwd2;
  logic [CNT_W-1:0]  stall_count;
  logic [CNT_W-1:0]  flush_count;

  modport master (
    output advance, flush, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_reg_write, id_lat,
    input  stall, id_bypass1, id_bypass2, ex_fwd1, ex_fwd2, stall_count, flush_count
  );

  modport slave (
    input  advance, flush, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_reg_write, id_lat,
    output stall, id_bypass1, id_bypass2, ex_fwd1, ex_fwd2, stall_count, flush_count
  );
endinterface

// File: rtl/pipe_fwd_match.sv
// Youngest-writer priority match of one source register against the in-flight entries.
module pipe_fwd_match
  import pipe_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int FW_W  = 2
) (
  input  entry_t [DEPTH-1:0]  entries,
  input  logic [ENT_RD_W-1:0] src,
  input  logic                used,
  output logic                hit,
  output logic [FW_W-1:0]     age,
  output logic                ready,
  output logic                bypass
);

  logic [ENT_LAT_W-1:0] hit_lat;

  always_comb begin
    hit     = 1'b0;
    age     = '0;
    hit_lat = '0;
    // Scan oldest to youngest so the lowest matching age is the one left standing.
    for (int j = DEPTH - 1; j >= 0; j--) begin
      if (used && (src != '0) && entries[j].v && (entries[j].rd == src)) begin
        hit     = 1'b1;
        age     = FW_W'(j);
        hit_lat = entries[j].lat;
      end
    end
    bypass = hit && (int'(age) == DEPTH - 1);
    ready  = !hit || bypass || ((int'(age) + 1) >= int'(hit_lat));
  end

endmodule

// File: rtl/pipe_scoreboard.sv
// In-flight writer shift register driving stall, WB bypass and EX forward selects.
module pipe_scoreboard
  import pipe_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int LAT_W  = 2,
  parameter int CNT_W  = 32
) (
  input logic             clk,
  input logic             reset,
  pipe_scoreboard_if.slave sb
);

  localparam int FW_W = $clog2(DEPTH);

  entry_t [DEPTH-1:0]  ent_q, ent_d;
  entry_t              id_ent;
  logic [REG_AW-1:0]   rs1_in, rs2_in, rd_in;
  logic [LAT_W-1:0]    lat_in;
  logic [ENT_RD_W-1:0] src1, src2;
  logic                hit1, hit2, rdy1, rdy2, byp1, byp2;
  logic [FW_W-1:0]     age1, age2, sel1, sel2;
  logic                stall_c;
  logic [FW_W-1:0]     fwd1_q, fwd1_d, fwd2_q, fwd2_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  assign rs1_in = sb.id_rs1;
  assign rs2_in = sb.id_rs2;
  assign rd_in  = sb.id_rd;
  assign lat_in = sb.id_lat;
  assign src1   = ENT_RD_W'(rs1_in);
  assign src2   = ENT_RD_W'(rs2_in);

  always_comb begin
    id_ent.v   = sb.id_valid & sb.id_reg_write & (rd_in != '0);
    id_ent.rd  = ENT_RD_W'(rd_in);
    id_ent.lat = eff_lat(int'(lat_in), DEPTH);
  end

  pipe_fwd_match #(.DEPTH(DEPTH), .FW_W(FW_W)) u_match1 (
    .entries(ent_q), .src(src1), .used(sb.id_rs1_used),
    .hit(hit1), .age(age1), .ready(rdy1), .bypass(byp1)
  );

  pipe_fwd_match #(.DEPTH(DEPTH), .FW_W(FW_W)) u_match2 (
    .entries(ent_q), .src(src2), .used(sb.id_rs2_used),
    .hit(hit2), .age(age2), .ready(rdy2), .bypass(byp2)
  );

  // A producer at age j is seen from EX next cycle at age j+1.
  assign sel1    = (hit1 && !byp1) ? age1 + FW_W'(1) : FW_W'(FWD_REGFILE);
  assign sel2    = (hit2 && !byp2) ? age2 + FW_W'(1) : FW_W'(FWD_REGFILE);
  assign stall_c = sb.id_valid & (~rdy1 | ~rdy2) & ~sb.flush;

  always_comb begin
    ent_d       = ent_q;
    fwd1_d      = fwd1_q;
    fwd2_d      = fwd2_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (sb.advance) begin
      ent_d[0] = (stall_c || sb.flush) ? '0 : id_ent;
      for (int k = 1; k < DEPTH; k++) begin
        ent_d[k] = ent_q[k-1];
      end
      if (stall_c || sb.flush || !sb.id_valid) begin
        fwd1_d = FW_W'(FWD_REGFILE);
        fwd2_d = FW_W'(FWD_REGFILE);
      end else begin
        fwd1_d = sel1;
        fwd2_d = sel2;
      end
      if (stall_c && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (sb.flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ent_q       <= '0;
      fwd1_q      <= '0;
      fwd2_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ent_q       <= ent_d;
      fwd1_q      <= fwd1_d;
      fwd2_q      <= fwd2_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign sb.stall       = stall_c;
  assign sb.id_bypass1  = byp1;
  assign sb.id_bypass2  = byp2;
  assign sb.ex_fwd1     = fwd1_q;
  assign sb.ex_fwd2     = fwd2_q;
  assign sb.stall_count = stall_cnt_q;
  assign sb.flush_count = flush_cnt_q;

endmodule

// File: doc/pipe_scoreboard.md
# pipe_scoreboard

Parametrised hazard and forwarding scoreboard for the in-order RISC-V pipeline. It replaces the fixed EX/MEM/WB forwarding and load-use logic with a shift-register record of in-flight writers, of configurable depth and per-instruction result latency. It sits beside the ID stage and has three jobs:
- issue stall decisions and ID-stage write-back bypass selects;
- register the EX-stage forward selects;
- support pipeline-wide hold and branch flush, and count stall and flush events.

## Interface
- REG_AW, default 5: register index width.
- DEPTH, default 3: number of post-ID stages tracked. Age 0 = EX, age DEPTH-1 = WB. Legal range is DEPTH ≥ 2.
- LAT_W, default 2: width of the latency field.
- CNT_W, default 32: width of the performance counters.
- FW_W, derived as $clog2(DEPTH): width of a forward select.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- advance  in  1  pipeline moves this cycle; 0 = global hold.
- flush  in  1  kill the instruction in ID (EX branch redirect).
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  REG_AW  source indices.
- id_rs1_used, id_rs2_used  in  1  the source is actually read.
- id_rd  in  REG_AW  destination.
- id_reg_write  in  1  instruction writes rd.
- id_lat  in  LAT_W  age at which the result becomes forwardable. 1 = ALU, 2 = load.
- stall  out  1  combinational; hold PC and IF/ID, insert a bubble.
- id_bypass1, id_bypass2  out  1  combinational; ID latches the WB value instead of the register-file read.
- ex_fwd1, ex_fwd2  out  FW_W  registered EX operand select. 0 = ID/EX operand; k = result held at age k.
- stall_count, flush_count  out  CNT_W  saturating event counters.

## Operation
- Entry state, ages 0..DEPTH-1: {v, rd, lat}.
  - v is set only if id_valid & id_reg_write & id_rd≠0.
  - An effective latency of 0 is treated as 1. Values above DEPTH-1 are clamped to DEPTH-1.
- Match rule, per used source s≠0:
  - Find the youngest entry j with v & rd==s. Lowest age wins.
  - If j == DEPTH-1, assert id_bypass. The next-cycle select is 0.
  - Otherwise, if j+1 < lat[j], the source is not ready and it requests a stall.
  - Otherwise the next-cycle select is j+1.
  - Unused sources, x0, and no match give select 0 and no bypass.
- stall = id_valid & (source 1 not ready | source 2 not ready) & ~flush.
- On a clock edge with advance=1:
  - Entries shift age k → k+1; the entry at age DEPTH-1 retires.
  - New age 0 is a bubble (v=0) if flush or stall. Otherwise it is the ID record.
  - ex_fwd1/2 ← computed selects. They are forced to 0 on stall, flush or ~id_valid.
  - stall_count increments when stall=1. flush_count increments when flush=1. Both saturate at all-ones.
- On a clock edge with advance=0: all state, ex_fwd and counters hold. stall and id_bypass remain combinational.
- flush and a stall request together: flush wins. A bubble is inserted, only flush_count increments, and the stall output is 0.
- Reset:
  - all v=0;
  - ex_fwd1=ex_fwd2=0;
  - both counters 0;
  - combinational outputs are therefore 0.
- Reset has priority over advance and flush. Asserting it mid-operation discards all in-flight records.

## Timing
- stall and id_bypass are valid in the same cycle as the ID inputs. There is no register between the inputs and these outputs.
- ex_fwd is valid in the cycle after the instruction leaves ID, i.e. while it is in EX.
- Load-use (lat=2) with the producer at age 0 gives exactly one stall cycle. In the next cycle the producer is at age 1, 2 ≥ 2, and the select is 2.
- ALU back-to-back (lat=1) gives zero stall cycles and a select of 1.
- For DEPTH=5 and lat=4, the worst case is 3 stall cycles.

## Structure
- Shared package pipe_pkg holds:
  - LAT_ALU=1, LAT_LOAD=2;
  - FWD_REGFILE=0;
  - the entry struct typedef {v, rd, lat}.
- Sub-module pipe_fwd_match is instantiated twice, once per source. It is a combinational youngest-match priority encoder over the entry array. Outputs: hit, age, ready, bypass.
- The top level holds the entry shift register, the ex_fwd registers and the counters.

## Test plan
- ALU chain: add x5 then add x6,x5,x5, DEPTH=3 → stall=0; next cycle ex_fwd1=ex_fwd2=1.
- Load-use: lw x5 then add x7,x5,x0 → one cycle with stall=1; then ex_fwd1=2, ex_fwd2=0, stall_count=1.
- WB bypass: write to x8, two unrelated instructions, then a read of x8 → id_bypass1=1 that cycle; next-cycle ex_fwd1=0.
- x0 and priority: addi x0 then addi x0 again, then a read of x0 → no stall, select 0. Two writers of x9 at ages 0 and 1 → select 1 (youngest).
- Flush/hold: a load-use pair with flush=1 → stall=0, bubble inserted, flush_count=1. Hold advance=0 for 3 cycles → entries, ex_fwd and counters are unchanged.
- DEPTH=5 build: lat=4 producer followed by a consumer → 3 stall cycles, then ex_fwd1=4. Assert reset mid-sequence → all outputs 0 the next cycle.
